// File: rtl/noc_pkg.sv
// Shared types and helpers for the NoC input buffer: FSM/phase encodings and header field extraction.
package noc_pkg;
   localparam int FLIT_W_DEF = 16;
   localparam int MAX_FLIT_W = 64;

   typedef enum logic [1:0] {IDLE, REQ, SEND} fsm_state_t;
   typedef enum logic [1:0] {HDR, SIZE, PAYLOAD} send_phase_t;

   // Target field is the low addr_w bits of the header; caller narrows the result.
   function automatic logic [MAX_FLIT_W-1:0] hdr_target(input logic [MAX_FLIT_W-1:0] flit,
                                                        input int addr_w);
      logic [MAX_FLIT_W-1:0] mask;
      mask = (MAX_FLIT_W'(1) << addr_w) - MAX_FLIT_W'(1);
      return flit & mask;
   endfunction
endpackage

// File: rtl/noc_input_buffer_if.sv
// Link, routing and switch handshake bundle of one router input port.
interface noc_input_buffer_if #(parameter int FLIT_W = 16, parameter int ADDR_W = 8);
   logic              rx;
   logic [FLIT_W-1:0] data_in;
   logic              credit_o;
   logic              h;
   logic              ack_h;
   logic [ADDR_W-1:0] target;
   logic              data_av;
   logic [FLIT_W-1:0] data_out;
   logic              data_ack;
   logic              sender;

   modport master (output rx, data_in, ack_h, data_ack,
                   input  credit_o, h, target, data_av, data_out, sender);
   modport slave  (input  rx, data_in, ack_h, data_ack,
                   output credit_o, h, target, data_av, data_out, sender);
endinterface

// File: rtl/noc_fifo.sv
// Pointer-based synchronous FIFO; head entry always visible on dout, no write-through bypass.
module noc_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic [AW:0]  count
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          wr, rd;

   // Guarded again here so a protocol error upstream can never corrupt the contents.
   assign wr    = push && !full;
   assign rd    = pop && !empty;
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rp];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (wr) wp <= wp + 1'b1;
         if (rd) rp <= rp + 1'b1;
         count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= din;
   end
endmodule

// File: rtl/noc_input_buffer.sv
// Credit-based router input buffer: stores flits, requests a route per header and streams
// header/size/payload to the switch.
module noc_input_buffer import noc_pkg::*; #(
   parameter int FLIT_W    = FLIT_W_DEF,
   parameter int BUF_DEPTH = 4,
   parameter int ADDR_W    = 8
) (
   input logic               clk,
   input logic               rst,
   noc_input_buffer_if.slave bus
);
   localparam int CW = $clog2(BUF_DEPTH);

   logic              push, pop, full, empty, pkt_end;
   logic [CW:0]       count;
   fsm_state_t        state;
   send_phase_t       phase;
   logic [FLIT_W-1:0] flit_cnt;
   logic              h_q, sender_q;
   logic [ADDR_W-1:0] target_q;

   assign bus.credit_o = !rst && (count < (CW+1)'(BUF_DEPTH));
   assign push         = bus.rx && bus.credit_o;
   assign bus.data_av  = sender_q && !empty;
   assign pop          = bus.data_av && bus.data_ack;
   assign bus.h        = h_q;
   assign bus.target   = target_q;
   assign bus.sender   = sender_q;

   noc_fifo #(.W(FLIT_W), .DEPTH(BUF_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (bus.data_in),
      .dout  (bus.data_out),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // A zero size flit ends the packet on its own pop; otherwise the last payload pop does.
   always_comb begin
      pkt_end = 1'b0;
      if (pop) begin
         if (phase == SIZE)    pkt_end = (bus.data_out == '0);
         if (phase == PAYLOAD) pkt_end = (flit_cnt == FLIT_W'(1));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         phase    <= HDR;
         flit_cnt <= '0;
         h_q      <= 1'b0;
         sender_q <= 1'b0;
         target_q <= '0;
      end else begin
         case (state)
            IDLE: if (!empty) begin
               state    <= REQ;
               h_q      <= 1'b1;
               target_q <= ADDR_W'(hdr_target(MAX_FLIT_W'(bus.data_out), ADDR_W));
            end
            REQ: if (bus.ack_h) begin
               state    <= SEND;
               h_q      <= 1'b0;
               sender_q <= 1'b1;
               phase    <= HDR;
            end
            SEND: if (pop) begin
               case (phase)
                  HDR:     phase <= SIZE;
                  SIZE:    begin
                     flit_cnt <= bus.data_out;
                     phase    <= PAYLOAD;
                  end
                  PAYLOAD: flit_cnt <= flit_cnt - FLIT_W'(1);
                  default: phase <= HDR;
               endcase
               if (pkt_end) begin
                  state    <= IDLE;
                  sender_q <= 1'b0;
                  phase    <= HDR;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   
   // full is only consumed inside the FIFO guard; kept for observability of the sub-module.
   logic unused_full;
   assign unused_full = full;
endmodule
